// File: rtl/fib_pkg.sv
// Shared constants, FSM state type, result payload and digit-adjust helper
// for the Fibonacci binary-to-BCD converter.
package fib_pkg;

  localparam int unsigned FIB_WIDTH      = 32;
  localparam int unsigned FIB_BCD_DIGITS = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } fib_state_e;

  typedef struct packed {
    logic [4*FIB_BCD_DIGITS-1:0] bcd;
    logic [3:0]                  num_digits;
  } fib_bcd_result_t;

  // Low three bits of the double-dabble add-3; bit 3 of that sum is just (d >= 5).
  function automatic logic [2:0] add3_lo(input logic [3:0] d);
    return (d >= 4'd5) ? 3'(d + 4'd3) : d[2:0];
  endfunction

endpackage

// File: rtl/fib_bcd_conv_if.sv
// Handshake bundle between a binary producer, the BCD converter and the result consumer.
interface fib_bcd_conv_if
  import fib_pkg::*;
#(
  parameter int unsigned WIDTH  = FIB_WIDTH,
  parameter int unsigned DIGITS = FIB_BCD_DIGITS
) ();

  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      bin;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   bcd;
  logic [3:0]            num_digits;

  modport master (
    output in_valid, bin, out_ready,
    input  in_ready, out_valid, bcd, num_digits
  );

  modport slave (
    input  in_valid, bin, out_ready,
    output in_ready, out_valid, bcd, num_digits
  );

endinterface

// File: rtl/fib_bcd_dabble_step.sv
// One combinational double-dabble step: add 3 to every BCD digit >= 5,
// then shift {acc, bin} left by one bit.
module fib_bcd_dabble_step
  import fib_pkg::*;
#(
  parameter int unsigned WIDTH  = FIB_WIDTH,
  parameter int unsigned DIGITS = FIB_BCD_DIGITS
) (
  input  logic [4*DIGITS-1:0] acc,
  input  logic [WIDTH-1:0]    bin,
  output logic [4*DIGITS-1:0] acc_nx,
  output logic [WIDTH-1:0]    bin_nx
);

  // carry[i] is the bit shifted into digit i: the binary MSB for digit 0,
  // otherwise bit 3 of the adjusted digit below. The top digit never reaches 5
  // when 10^DIGITS > 2^WIDTH-1, so its outgoing bit is always zero.
  logic [DIGITS-1:0] carry;

  always_comb begin
    carry    = '0;
    acc_nx   = '0;
    carry[0] = bin[WIDTH-1];
    for (int unsigned i = 1; i < DIGITS; i++) begin
      carry[i] = (acc[4*(i-1) +: 4] >= 4'd5);
    end
    for (int unsigned i = 0; i < DIGITS; i++) begin
      acc_nx[4*i +: 4] = {add3_lo(acc[4*i +: 4]), carry[i]};
    end
  end

  assign bin_nx = {bin[WIDTH-2:0], 1'b0};

endmodule

// File: rtl/fib_bcd_conv.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock) for the Fibonacci output.
// Define FIB_BCD_DIGITS_EN to compute num_digits; otherwise num_digits is driven to zero.
module fib_bcd_conv
  import fib_pkg::*;
#(
  parameter int unsigned WIDTH  = FIB_WIDTH,
  parameter int unsigned DIGITS = FIB_BCD_DIGITS
) (
  input  logic          clk,
  input  logic          rst_n,
  fib_bcd_conv_if.slave io
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  fib_state_e       state;
  fib_state_e       state_nx;
  logic [CNT_W-1:0] cnt;
  logic [BCD_W-1:0] acc;
  logic [BCD_W-1:0] acc_nx;
  logic [BCD_W-1:0] bcd_q;
  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] sh_nx;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             do_load;
  logic             do_step;
  logic             do_done;

  fib_bcd_dabble_step #(
    .WIDTH  (WIDTH),
    .DIGITS (DIGITS)
  ) u_step (
    .acc    (acc),
    .bin    (sh),
    .acc_nx (acc_nx),
    .bin_nx (sh_nx)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state; SHIFT lingers one cycle at cnt==0 to publish the result
  always_comb begin
    state_nx = state;
    do_load  = 1'b0;
    do_step  = 1'b0;
    do_done  = 1'b0;
    case (state)
      IDLE: begin
        if (io.in_valid && in_ready_q) begin
          do_load  = 1'b1;
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt != '0) begin
          do_step = 1'b1;
        end else begin
          do_done  = 1'b1;
          state_nx = DONE;
        end
      end
      DONE: begin
        if (io.out_ready) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Datapath and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      acc         <= '0;
      sh          <= '0;
      bcd_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      in_ready_q  <= (state_nx == IDLE);
      out_valid_q <= (state_nx == DONE);
      if (do_load) begin
        sh  <= io.bin;
        acc <= '0;
        cnt <= CNT_W'(WIDTH);
      end else if (do_step) begin
        sh  <= sh_nx;
        acc <= acc_nx;
        cnt <= cnt - CNT_W'(1);
      end
      if (do_done) begin
        bcd_q <= acc;
      end
    end
  end

  assign io.in_ready  = in_ready_q;
  assign io.out_valid = out_valid_q;
  assign io.bcd       = bcd_q;

`ifdef FIB_BCD_DIGITS_EN
  logic [3:0] nd_c;
  logic [3:0] nd_q;

  // Highest nonzero digit index + 1, at least 1 so a zero result reads as one digit
  always_comb begin
    nd_c = 4'd1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (acc[4*i +: 4] != 4'd0) begin
        nd_c = 4'(i + 1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nd_q <= 4'd0;
    end else if (do_done) begin
      nd_q <= nd_c;
    end
  end

  assign io.num_digits = nd_q;
`else
  assign io.num_digits = 4'd0;
`endif

endmodule

// File: tb/tb_fib_bcd_conv.sv
// Scoreboard bench for fib_bcd_conv: directed vectors push expected results,
// a negedge monitor pops and compares on every output handshake.
module tb_fib_bcd_conv;
  import fib_pkg::*;

`ifdef FIB_BCD_DIGITS_EN
  localparam bit ND_EN = 1'b1;
`else
  localparam bit ND_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  fib_bcd_conv_if #(.WIDTH(FIB_WIDTH), .DIGITS(FIB_BCD_DIGITS)) io ();

  fib_bcd_conv #(.WIDTH(FIB_WIDTH), .DIGITS(FIB_BCD_DIGITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io)
  );

  int checks = 0;
  int errors = 0;
  fib_bcd_result_t sb[$];
  fib_bcd_result_t mon_exp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [3:0] nd_exp(input logic [3:0] n);
    return n & {4{ND_EN}};
  endfunction

  function automatic logic [39:0] to_bcd(input longint unsigned v);
    logic [39:0]      r;
    longint unsigned  x;
    r = '0;
    x = v;
    for (int i = 0; i < 10; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [3:0] count_nd(input logic [39:0] b);
    logic [3:0] n;
    n = 4'd1;
    for (int i = 0; i < 10; i++) begin
      if (b[4*i +: 4] != 4'd0) n = 4'(i + 1);
    end
    return n;
  endfunction

  // Monitor: a result is consumed at the next posedge when valid and ready at negedge
  always @(negedge clk) begin
    if (rst_n && io.out_valid && io.out_ready) begin
      check("sb_has_entry", 64'(sb.size() != 0), 64'(1));
      if (sb.size() != 0) begin
        mon_exp = sb.pop_front();
        check("bcd", 64'(io.bcd), 64'(mon_exp.bcd));
        check("num_digits", 64'(io.num_digits), 64'(mon_exp.num_digits));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_result(input logic [39:0] b, input logic [3:0] n);
    fib_bcd_result_t e;
    e.bcd        = b;
    e.num_digits = nd_exp(n);
    sb.push_back(e);
  endtask

  task automatic start(input logic [31:0] v, input bit hold_valid);
    int n;
    n = 0;
    while (!io.in_ready && n < 200) begin
      tick();
      n++;
    end
    check("in_ready_before_accept", 64'(io.in_ready), 64'(1));
    io.in_valid = 1'b1;
    io.bin      = v;
    tick();
    if (!hold_valid) io.in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int edges);
    edges = 0;
    while (!io.out_valid && edges < 200) begin
      tick();
      edges++;
    end
    check("out_valid_seen", 64'(io.out_valid), 64'(1));
  endtask

  task automatic convert(input logic [31:0] v, input logic [39:0] b, input logic [3:0] n);
    int edges;
    expect_result(b, n);
    start(v, 1'b0);
    wait_valid(edges);
    check("latency_edges", 64'(edges), 64'(FIB_WIDTH + 1));
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int              edges;
    int              n;
    longint unsigned f_prev;
    longint unsigned f_cur;
    longint unsigned f_nxt;
    logic [39:0]     b;

    io.in_valid  = 1'b0;
    io.bin       = '0;
    io.out_ready = 1'b1;

    #3 rst_n = 1'b0;
    #10;
    check("rst_out_valid", 64'(io.out_valid), 64'(0));
    check("rst_bcd", 64'(io.bcd), 64'(0));
    check("rst_num_digits", 64'(io.num_digits), 64'(0));
    tick();
    rst_n = 1'b1;
    tick();
    check("rst_in_ready_after_release", 64'(io.in_ready), 64'(1));
    check("rst_out_valid_after_release", 64'(io.out_valid), 64'(0));

    // Zero input: latency and single-digit result
    expect_result(40'h0000000000, 4'd1);
    start(32'd0, 1'b0);
    wait_valid(edges);
    check("zero_latency_edges", 64'(edges), 64'(33));
    check("done_in_ready_low", 64'(io.in_ready), 64'(0));
    tick();

    // Directed hand-computed values
    convert(32'd2971215073, 40'h2971215073, 4'd10);
    convert(32'd4294967295, 40'h4294967295, 4'd10);
    convert(32'd1000000000, 40'h1000000000, 4'd10);
    convert(32'd832040,     40'h0000832040, 4'd6);
    convert(32'd9,          40'h0000000009, 4'd1);
    convert(32'd10,         40'h0000000010, 4'd2);
    convert(32'd99999,      40'h0000099999, 4'd5);

    // Consumer stalls for 5 cycles after completion
    io.out_ready = 1'b0;
    expect_result(40'h0000012345, 4'd5);
    start(32'd12345, 1'b0);
    wait_valid(edges);
    for (int i = 0; i < 5; i++) begin
      check("stall_out_valid", 64'(io.out_valid), 64'(1));
      check("stall_bcd", 64'(io.bcd), 64'h0000012345);
      check("stall_num_digits", 64'(io.num_digits), 64'(nd_exp(4'd5)));
      check("stall_in_ready", 64'(io.in_ready), 64'(0));
      tick();
    end
    io.out_ready = 1'b1;
    tick();
    check("idle_in_ready", 64'(io.in_ready), 64'(1));
    check("idle_bcd_held", 64'(io.bcd), 64'h0000012345);

    // Reset at shift step 10 aborts the conversion
    start(32'd4294967295, 1'b0);
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(io.out_valid), 64'(0));
    check("midrst_bcd", 64'(io.bcd), 64'(0));
    check("midrst_num_digits", 64'(io.num_digits), 64'(0));
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("midrst_in_ready_after", 64'(io.in_ready), 64'(1));
    repeat (40) tick();
    check("midrst_no_stale_valid", 64'(io.out_valid), 64'(0));
    convert(32'd2971215073, 40'h2971215073, 4'd10);

    // in_valid held high with a changing bin during SHIFT
    expect_result(40'h0000832040, 4'd6);
    start(32'd832040, 1'b1);
    for (int i = 0; i < 20; i++) begin
      io.bin = $urandom;
      check("busy_in_ready", 64'(io.in_ready), 64'(0));
      tick();
    end
    io.in_valid = 1'b0;
    wait_valid(edges);
    tick();

    // Fibonacci sequence n = 1..47
    f_prev = 0;
    f_cur  = 1;
    for (int k = 1; k <= 47; k++) begin
      b = to_bcd(f_cur);
      convert(32'(f_cur), b, count_nd(b));
      f_nxt  = f_prev + f_cur;
      f_prev = f_cur;
      f_cur  = f_nxt;
    end

    n = 0;
    while (sb.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    check("sb_drained", 64'(sb.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
